// File: rtl/chunked_addsub_pkg.sv
// Shared types and helpers for the chunked two's-complement adder/subtractor.
// State encodings are fixed so the waveform decode matches the lab tooling.
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  // Signed overflow: operands share a sign but the raw result does not.
  function automatic logic signed_ovf(input logic s_a, input logic s_b, input logic msb);
    return (s_a == s_b) && (msb != s_a);
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk_add.sv
// CHUNK-bit ripple adder built from full-adder cells; one chunk of the
// multi-cycle operation is resolved per clock.
module chunk_add
  import chunked_addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Ripple the carry through the cells; a variable keeps the chain acyclic.
  always_comb begin
    logic       carry_v;
    logic [1:0] fa_v;
    carry_v = cin;
    sum     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      fa_v    = full_add(a[i], b[i], carry_v);
      sum[i]  = fa_v[0];
      carry_v = fa_v[1];
    end
    cout = carry_v;
  end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock,
// start/busy/done handshake, raw carry-out, signed overflow and optional saturation.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Sat,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             OverFlow
);

  localparam int              NCH        = WIDTH / CHUNK;
  localparam int              CW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]   LAST_CNT   = CW'(NCH - 1);
  localparam logic            SAT_EN_BIT = (SAT_EN != 0);
  localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_r, next_state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] op_a_r, op_b_r, res_r;
  logic             carry_r, sat_l_r, s_a_r, s_b_r;
  logic             busy_r, done_r, carry_out_r, ovf_r;
  logic [WIDTH-1:0] sum_r;

  logic [WIDTH-1:0] b_in_s, res_shift_s, sum_fin_s;
  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_cout_s, start_ok_s, last_s, ovf_s, busy_s, done_s;

  assign b_in_s     = Sub ? ~B : B;
  assign start_ok_s = Start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_s     = (state_r == ST_RUN) && (cnt_r == LAST_CNT);

  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .a    (op_a_r[CHUNK-1:0]),
    .b    (op_b_r[CHUNK-1:0]),
    .cin  (carry_r),
    .sum  (chunk_sum_s),
    .cout (chunk_cout_s)
  );

  // New chunk enters at the top so the LSB chunk lands at bit 0 after NCH cycles.
  assign res_shift_s = (res_r >> CHUNK) | (WIDTH'(chunk_sum_s) << (WIDTH - CHUNK));
  assign ovf_s       = signed_ovf(s_a_r, s_b_r, res_shift_s[WIDTH-1]);

  // Saturated or raw result presented at DONE entry.
  always_comb begin
    sum_fin_s = res_shift_s;
    if (ovf_s && sat_l_r) begin
      sum_fin_s = s_a_r ? SAT_MIN : SAT_MAX;
    end else begin
      sum_fin_s = res_shift_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: next_state_s = Start ? ST_RUN : ST_IDLE;
      ST_RUN:  next_state_s = (cnt_r == LAST_CNT) ? ST_DONE : ST_RUN;
      ST_DONE: next_state_s = Start ? ST_RUN : ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state, then registered.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_state_s)
      ST_RUN:  busy_s = 1'b1;
      ST_DONE: done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand latch, per-chunk shift and carry/counter update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      sat_l_r <= 1'b0;
      s_a_r   <= 1'b0;
      s_b_r   <= 1'b0;
      cnt_r   <= '0;
    end else if (start_ok_s) begin
      op_a_r  <= A;
      op_b_r  <= b_in_s;
      carry_r <= Sub;
      sat_l_r <= Sat & SAT_EN_BIT;
      s_a_r   <= A[WIDTH-1];
      s_b_r   <= b_in_s[WIDTH-1];
      cnt_r   <= '0;
    end else if (state_r == ST_RUN) begin
      op_a_r  <= op_a_r >> CHUNK;
      op_b_r  <= op_b_r >> CHUNK;
      res_r   <= res_shift_s;
      carry_r <= chunk_cout_s;
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  // Registered outputs; results only change on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      if (last_s) begin
        sum_r       <= sum_fin_s;
        carry_out_r <= chunk_cout_s;
        ovf_r       <= ovf_s;
      end
    end
  end

  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Sum      = sum_r;
  assign CarryOut = carry_out_r;
  assign OverFlow = ovf_r;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench: a 16/4 saturating instance and an 8/2 non-saturating
// instance checked against an integer-arithmetic reference model.
module tb_chunked_addsub;

  logic clk = 1'b0;
  logic rst_n;
  logic start16, sub16, sat16, busy16, done16, co16, ov16;
  logic [15:0] a16, b16, sum16;
  logic start8, sub8, sat8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, sum8;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.WIDTH(16), .CHUNK(4), .SAT_EN(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .Start(start16), .A(a16), .B(b16), .Sub(sub16), .Sat(sat16),
    .Busy(busy16), .Done(done16), .Sum(sum16), .CarryOut(co16), .OverFlow(ov16));

  chunked_addsub #(.WIDTH(8), .CHUNK(2), .SAT_EN(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .Start(start8), .A(a8), .B(b8), .Sub(sub8), .Sat(sat8),
    .Busy(busy8), .Done(done8), .Sum(sum8), .CarryOut(co8), .OverFlow(ov8));

  // Mathematical reference: exact signed result, range check, modular wrap.
  function automatic void model(input int w, input longint a, input longint b, input bit sub,
                                input bit sat, output longint sum, output bit co, output bit ov);
    longint m, half, sa, sb, t;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    t    = sub ? sa - sb : sa + sb;
    ov   = (t >= half) || (t < -half);
    co   = sub ? (a >= b) : (a + b >= m);
    if (ov && sat) sum = (t > 0) ? half - 1 : half;
    else           sum = ((t % m) + m) % m;
  endfunction

  // Drives one operation from the current cycle and waits (bounded) for Done.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b, input bit sub,
                       input bit sat, output logic [15:0] s, output bit co, output bit ov,
                       output int lat, output int busy_cnt);
    if (sel == 0) begin a16 = a; b16 = b; sub16 = sub; sat16 = sat; start16 = 1'b1; end
    else begin a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; sat8 = sat; start8 = 1'b1; end
    @(posedge clk); #1;
    start16 = 1'b0; start8 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); sat16 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); sat8 = 1'($urandom);
    lat = 1; busy_cnt = 0;
    while (lat < 40) begin
      if ((sel == 0) ? done16 : done8) break;
      if ((sel == 0) ? busy16 : busy8) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    s  = (sel == 0) ? sum16 : {8'h00, sum8};
    co = (sel == 0) ? co16 : co8;
    ov = (sel == 0) ? ov16 : ov8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start16 = 1'b0; a16 = 16'h0; b16 = 16'h0; sub16 = 1'b0; sat16 = 1'b0;
    start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; sub8 = 1'b0; sat8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy16, done16, co16, ov16, sum16} !== 20'h0) begin
      bad++; $display("FAIL reset16: got %h want 0", {busy16, done16, co16, ov16, sum16});
    end
    total++;
    if ({busy8, done8, co8, ov8, sum8} !== 12'h0) begin
      bad++; $display("FAIL reset8: got %h want 0", {busy8, done8, co8, ov8, sum8});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int          t_sel [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    logic [15:0] t_a   [8] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h007F, 16'h007F, 16'h0012};
    logic [15:0] t_b   [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0021};
    bit          t_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit          t_sat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] e_sum [8] = '{16'h5555, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0080, 16'h0080, 16'h0033};
    bit          e_co  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit          e_ov  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] s;
    bit co, ov;
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      do_op(t_sel[i], t_a[i], t_b[i], t_sub[i], t_sat[i], s, co, ov, lat, bc);
      total++;
      if (s !== e_sum[i]) begin bad++; $display("FAIL directed%0d sum: got %h want %h", i, s, e_sum[i]); end
      total++;
      if (co !== e_co[i]) begin bad++; $display("FAIL directed%0d carry: got %0d want %0d", i, co, e_co[i]); end
      total++;
      if (ov !== e_ov[i]) begin bad++; $display("FAIL directed%0d ovf: got %0d want %0d", i, ov, e_ov[i]); end
      total++;
      if (lat !== 5) begin bad++; $display("FAIL directed%0d latency: got %0d want 5", i, lat); end
      total++;
      if (bc !== 4) begin bad++; $display("FAIL directed%0d busy: got %0d want 4", i, bc); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, s;
    bit sub, sat, co, ov, e_co, e_ov;
    longint e_sum;
    int lat, bc, sel, w;
    for (int i = 0; i < 40; i++) begin
      sel = i % 2;
      w   = (sel == 0) ? 16 : 8;
      a   = 16'($urandom); b = 16'($urandom);
      if (sel == 1) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
      sub = 1'($urandom); sat = 1'($urandom);
      model(w, longint'(a), longint'(b), sub, sat && (sel == 0), e_sum, e_co, e_ov);
      do_op(sel, a, b, sub, sat, s, co, ov, lat, bc);
      total++;
      if (s !== e_sum[15:0]) begin
        bad++; $display("FAIL rand%0d sum: got %h want %h (a=%h b=%h sub=%0d sat=%0d)", i, s, e_sum[15:0], a, b, sub, sat);
      end
      total++;
      if ({co, ov} !== {e_co, e_ov}) begin
        bad++; $display("FAIL rand%0d flags: got co=%0d ov=%0d want co=%0d ov=%0d", i, co, ov, e_co, e_ov);
      end
      total++;
      if (lat !== 5) begin bad++; $display("FAIL rand%0d latency: got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_start_in_run();
    int cyc, ndone, done_cyc;
    logic [15:0] s;
    bit co, ov, e_co, e_ov;
    longint e_sum;
    model(16, 64'h1111, 64'h2222, 1'b0, 1'b0, e_sum, e_co, e_ov);
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; sat16 = 1'b0; start16 = 1'b1;
    ndone = 0; done_cyc = -1; s = 16'h0; co = 1'b0; ov = 1'b0;
    for (cyc = 1; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      start16 = (cyc == 2);
      if (cyc == 2) begin a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; sat16 = 1'b1; end
      if (done16) begin ndone++; done_cyc = cyc; s = sum16; co = co16; ov = ov16; end
    end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL run_start done_count: got %0d want 1", ndone); end
    total++;
    if (done_cyc !== 5) begin bad++; $display("FAIL run_start done_cycle: got %0d want 5", done_cyc); end
    total++;
    if ({s, co, ov} !== {e_sum[15:0], e_co, e_ov}) begin
      bad++; $display("FAIL run_start result: got %h/%0d/%0d want %h/%0d/%0d", s, co, ov, e_sum[15:0], e_co, e_ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    bit co, ov, held_ok;
    int lat, bc, cyc;
    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, s, co, ov, lat, bc);
    total++;
    if (s !== 16'h5555) begin bad++; $display("FAIL b2b first sum: got %h want 5555", s); end
    a16 = 16'h0003; b16 = 16'h0005; sub16 = 1'b1; sat16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 1; held_ok = 1'b1;
    while (cyc < 40 && !done16) begin
      if (sum16 !== 16'h5555 || busy16 !== 1'b1) held_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!held_ok) begin bad++; $display("FAIL b2b hold: got changed Sum/Busy during run want 5555 held, busy 1"); end
    total++;
    if (cyc !== 5) begin bad++; $display("FAIL b2b latency: got %0d want 5", cyc); end
    total++;
    if ({sum16, co16, ov16} !== {16'hFFFE, 1'b0, 1'b0}) begin
      bad++; $display("FAIL b2b second: got %h/%0d/%0d want fffe/0/0", sum16, co16, ov16);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] s;
    bit co, ov, quiet;
    int lat, bc;
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, bc);
    a16 = 16'h1234; b16 = 16'h0101; sub16 = 1'b0; start16 = 1'b1;
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy16, done16, co16, ov16, sum16} !== 20'h0) begin
      bad++; $display("FAIL midreset async16: got %h want 0", {busy16, done16, co16, ov16, sum16});
    end
    total++;
    if ({busy8, done8, co8, ov8, sum8} !== 12'h0) begin
      bad++; $display("FAIL midreset async8: got %h want 0", {busy8, done8, co8, ov8, sum8});
    end
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done16 || done8 || busy16 || busy8) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL midreset quiet: got Done/Busy activity want none"); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, s, co, ov, lat, bc);
    total++;
    if ({s, co, ov, lat} !== {16'h1010, 1'b0, 1'b0, 32'd5}) begin
      bad++; $display("FAIL midreset fresh: got %h/%0d/%0d lat %0d want 1010/0/0 lat 5", s, co, ov, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
